path_node_mem_arbiter: RTL and testbench
========================================

Name: path_node_mem_arbiter

Overview:
- Shares the 16-entry x 65-bit path node block RAM between two requesters: the path-search engine (port 0) and the host/config loader (port 1).
- Also contains an init-sweep engine that re-arms every node record for a new search. It keeps the node id and wall bit and resets the prev, g and f fields.
- Sits between the requesters and the RAM's separate write port and registered read port, which has 1-cycle read latency.

Parameters:
- ADDR_W, 4, node address width.
- DEPTH, 16, number of node records (2^ADDR_W).
- REC_W, 65, record width: [64:49] id, [48:33] prev, [32:17] g, [16:1] f, [0] wall.

Ports:
- system1000  in  1  clock.
- system1000_rstn  in  1  reset. Asynchronous assert, active-low.
- req0_valid  in  1  search engine request valid.
- req0_ready  out  1  search engine request accepted.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_W  record address.
- req0_wdata  in  REC_W  write record.
- rsp0_valid  out  1  read data valid for port 0.
- req1_valid, req1_ready, req1_we, req1_addr, req1_wdata  same as port 0, for the host.
- rsp1_valid  out  1  read data valid for port 1.
- rsp_rdata  out  REC_W  read data, shared by both ports.
- init_start  in  1  one-cycle pulse that requests an init sweep.
- init_busy  out  1  sweep in progress.
- init_done  out  1  one-cycle pulse when the sweep completes.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_W  RAM write address.
- mem_wdata  out  REC_W  RAM write data.
- mem_raddr  out  ADDR_W  RAM read address.
- mem_rdout  in  REC_W  RAM registered read data.

Behaviour:
- Reset values:
  - state = IDLE, rr pointer = favour port 0.
  - mem_we = 0, mem_waddr = 0, mem_wdata = 0, mem_raddr = 0.
  - rsp0_valid = 0, rsp1_valid = 0, rsp_rdata = 0.
  - init_busy = 0, init_done = 0.
  - req*_ready = 0 while reset is asserted.
- Reset mid-sweep or mid-transaction aborts it. Partially swept RAM contents are left as they are.
- States:
  - IDLE: arbitration is active.
  - DRAIN: 2 cycles, ready = 0, lets in-flight reads complete.
  - SWEEP
  - DONE: 1 cycle, pulses init_done.
- Transitions:
  - IDLE with init_start -> DRAIN -> SWEEP -> DONE -> IDLE.
  - init_start outside IDLE is ignored.
  - When init_start and a request arrive in the same IDLE cycle, init_start wins: no request is granted that cycle.
- Arbitration (IDLE only), at most one grant per cycle:
  - Only one port valid: that port is granted.
  - Both ports valid: the port favoured by the rr pointer is granted, and the pointer then flips to the other port.
  - A grant to a lone requester also sets the pointer to favour the other port.
  - req*_ready is combinational from state, both valids and the pointer.
- Pipeline for a request handshaked in cycle n:
  - The mem_* outputs are registered and are driven in cycle n+1.
  - Write: mem_we = 1 for exactly cycle n+1.
  - Read: mem_raddr is set in cycle n+1. mem_rdout arrives in n+2 and is registered to rsp_rdata, with rsp*_valid high in cycle n+3.
  - Read latency is therefore 3 cycles, handshake to response.
  - mem_raddr holds its last value when no read is issued.
  - Back-to-back requests are accepted every cycle, and responses return in order.
- Read-after-write: a write accepted in cycle n followed by a read accepted in cycle n+1 or later to the same address returns the new data.
- init_busy is high from the DRAIN entry through the last SWEEP write cycle.
- SWEEP:
  - Issues reads for addresses 0..DEPTH-1 on consecutive cycles.
  - Each returning record r is written back at the same address 2 cycles after its read issue, as {r[64:49], 16'hFFFF, 16'h7FFF, 16'h7FFF, r[0]}.
  - Reads and writes overlap on the separate ports, and the write address always lags the read address by 2, so there is no hazard.
  - The sweep lasts DEPTH+2 cycles, and init_done pulses the cycle after the final write.
- rsp*_valid never asserts for sweep reads.

Test Plan:
- Reset, then release: all outputs are 0. req0_valid=1 read addr 5 -> req0_ready=1, mem_raddr=5 next cycle, rsp0_valid=1 three cycles after the handshake, rsp_rdata = RAM[5].
- Both ports hold valid continuously, port 0 reading addr 1 and port 1 reading addr 2 -> grants alternate 0,1,0,1. rsp0 and rsp1 alternate in order with the correct data.
- Port 1 writes addr 3 = {16'd3, 16'd7, 16'd2, 16'd4, 1'b1}, then port 0 reads addr 3 in the next cycle -> rsp_rdata equals the written record.
- RAM preloaded with prev=1, g=2, f=3 and arbitrary walls; pulse init_start -> init_busy high for DEPTH+4 cycles and ready low throughout. Afterwards every record reads {id, FFFF, 7FFF, 7FFF, wall unchanged}, and init_done pulses once.
- A read is accepted one cycle before init_start -> its rsp0_valid still arrives with correct data during DRAIN. A second init_start during SWEEP is ignored.
- Assert system1000_rstn=0 mid-SWEEP at address 7 -> all outputs drop to their reset values asynchronously. After release, state is IDLE and requests are granted again.

Source files
------------

// File: rtl/path_node_mem_arbiter.sv
// Two-port arbiter in front of the path node RAM, plus an init-sweep engine
// that re-arms every record (prev/g/f reset, id and wall kept) for a new search.
module path_node_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int REC_W  = 65
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [REC_W-1:0]  req0_wdata,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [REC_W-1:0]  req1_wdata,
  output logic              rsp1_valid,
  output logic [REC_W-1:0]  rsp_rdata,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [REC_W-1:0]  mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [REC_W-1:0]  mem_rdout
);
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] SWP_LAST  = CNT_W'(DEPTH + 1);
  localparam logic [CNT_W-1:0] SWP_ISSUE = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, SWEEP, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rr_q, rr_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_waddr_q, mem_waddr_d;
  logic [REC_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0]  mem_raddr_q, mem_raddr_d;
  logic               rd1_q, rd1_d, rd1_port_q, rd1_port_d, rd1_swp_q, rd1_swp_d;
  logic               rd2_q, rd2_d, rd2_port_q, rd2_port_d, rd2_swp_q, rd2_swp_d;
  logic [ADDR_W-1:0]  rd2_addr_q, rd2_addr_d;
  logic               rsp0_q, rsp0_d, rsp1_q, rsp1_d;
  logic [REC_W-1:0]   rsp_rdata_q, rsp_rdata_d;

  logic               arb_en, gnt0, gnt1, gnt;
  logic               swp_issue;
  logic [ADDR_W-1:0]  swp_addr;

  // init_start takes priority over any request in the same IDLE cycle
  assign arb_en = system1000_rstn && (state_q == IDLE) && !init_start;
  assign gnt0   = arb_en && req0_valid && (!req1_valid || !rr_q);
  assign gnt1   = arb_en && req1_valid && (!req0_valid || rr_q);
  assign gnt    = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign init_busy  = (state_q == DRAIN) || (state_q == SWEEP);
  assign init_done  = (state_q == DONE);
  assign mem_we     = mem_we_q;
  assign mem_waddr  = mem_waddr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_raddr  = mem_raddr_q;
  assign rsp0_valid = rsp0_q;
  assign rsp1_valid = rsp1_q;
  assign rsp_rdata  = rsp_rdata_q;

  // Sweep read for address 0 is issued in the last DRAIN cycle so the final
  // write-back lands in the last SWEEP cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    swp_issue = 1'b0;
    swp_addr  = '0;
    case (state_q)
      IDLE: if (init_start) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: if (cnt_q == CNT_W'(1)) begin
        state_d   = SWEEP;
        cnt_d     = '0;
        swp_issue = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      SWEEP: begin
        if (cnt_q < SWP_ISSUE) begin
          swp_issue = 1'b1;
          swp_addr  = ADDR_W'(cnt_q + 1'b1);
        end
        if (cnt_q == SWP_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_d        = rr_q;
    mem_we_d    = 1'b0;
    mem_waddr_d = mem_waddr_q;
    mem_wdata_d = mem_wdata_q;
    mem_raddr_d = mem_raddr_q;
    rd1_d       = 1'b0;
    rd1_port_d  = 1'b0;
    rd1_swp_d   = 1'b0;
    if (gnt0)      rr_d = 1'b1;
    else if (gnt1) rr_d = 1'b0;
    if (gnt) begin
      if (gnt1 ? req1_we : req0_we) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = gnt1 ? req1_addr : req0_addr;
        mem_wdata_d = gnt1 ? req1_wdata : req0_wdata;
      end else begin
        mem_raddr_d = gnt1 ? req1_addr : req0_addr;
        rd1_d       = 1'b1;
        rd1_port_d  = gnt1;
      end
    end
    if (swp_issue) begin
      mem_raddr_d = swp_addr;
      rd1_d       = 1'b1;
      rd1_swp_d   = 1'b1;
    end
    rd2_d      = rd1_q;
    rd2_port_d = rd1_port_q;
    rd2_swp_d  = rd1_swp_q;
    rd2_addr_d = mem_raddr_q;
    // Write-back address trails the read address by two cycles
    if (rd2_q && rd2_swp_q) begin
      mem_we_d    = 1'b1;
      mem_waddr_d = rd2_addr_q;
      mem_wdata_d = {mem_rdout[64:49], 16'hFFFF, 16'h7FFF, 16'h7FFF, mem_rdout[0]};
    end
    rsp0_d      = rd2_q && !rd2_swp_q && !rd2_port_q;
    rsp1_d      = rd2_q && !rd2_swp_q && rd2_port_q;
    rsp_rdata_d = (rd2_q && !rd2_swp_q) ? mem_rdout : rsp_rdata_q;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rr_q        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_waddr_q <= '0;
      mem_wdata_q <= '0;
      mem_raddr_q <= '0;
      rd1_q       <= 1'b0;
      rd1_port_q  <= 1'b0;
      rd1_swp_q   <= 1'b0;
      rd2_q       <= 1'b0;
      rd2_port_q  <= 1'b0;
      rd2_swp_q   <= 1'b0;
      rd2_addr_q  <= '0;
      rsp0_q      <= 1'b0;
      rsp1_q      <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      mem_we_q    <= mem_we_d;
      mem_waddr_q <= mem_waddr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_raddr_q <= mem_raddr_d;
      rd1_q       <= rd1_d;
      rd1_port_q  <= rd1_port_d;
      rd1_swp_q   <= rd1_swp_d;
      rd2_q       <= rd2_d;
      rd2_port_q  <= rd2_port_d;
      rd2_swp_q   <= rd2_swp_d;
      rd2_addr_q  <= rd2_addr_d;
      rsp0_q      <= rsp0_d;
      rsp1_q      <= rsp1_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end
endmodule

// File: tb/tb_path_node_mem_arbiter.sv
// Directed bench for path_node_mem_arbiter with a registered-read RAM model.
module tb_path_node_mem_arbiter;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
  logic [3:0]  req0_addr = 0, req1_addr = 0;
  logic [64:0] req0_wdata = 0, req1_wdata = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [64:0] rsp_rdata;
  logic        init_start = 0, init_busy, init_done;
  logic        mem_we;
  logic [3:0]  mem_waddr, mem_raddr;
  logic [64:0] mem_wdata, mem_rdout;

  logic [64:0] ram [16];
  logic        pre_done = 1'b0;
  int          n_chk = 0, n_fail = 0;

  localparam logic [64:0] W3 = {16'd3, 16'd7, 16'd2, 16'd4, 1'b1};

  path_node_mem_arbiter dut (
    .system1000(clk), .system1000_rstn(rstn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .init_start(init_start), .init_busy(init_busy),
    .init_done(init_done), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdout(mem_rdout)
  );

  always #5 clk = ~clk;

  function automatic logic [64:0] pre(input int i);
    logic wall;
    wall = (i % 3 == 0);
    return {16'h0100 + 16'(i), 16'd1, 16'd2, 16'd3, wall};
  endfunction

  function automatic logic [64:0] swept(input logic [64:0] r);
    return {r[64:49], 16'hFFFF, 16'h7FFF, 16'h7FFF, r[0]};
  endfunction

  always @(posedge clk) begin
    if (!pre_done) begin
      for (int i = 0; i < 16; i++) ram[i] <= pre(i);
      pre_done <= 1'b1;
    end else if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
    end
    mem_rdout <= ram[mem_raddr];
  end

  function automatic logic [159:0] outs();
    return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata, init_busy,
            init_done, mem_we, mem_waddr, mem_wdata, mem_raddr};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt, done_cnt, rdy_bad, rsp_bad;
    logic found;

    // reset, including ready held low with a valid request present
    req0_valid = 1;
    tick(); tick(); tick();
    chk("reset_outs", outs(), '0);
    rstn = 1; req0_valid = 0;
    tick();
    chk("post_reset_outs", outs(), '0);

    // lone port 0 read of addr 5
    req0_valid = 1; req0_addr = 5; #1;
    chk("rd5_ready", req0_ready, 1);
    tick(); req0_valid = 0; #1;
    chk("rd5_raddr", mem_raddr, 5);
    chk("rd5_no_we", mem_we, 0);
    tick(); tick();
    chk("rd5_rsp0", {rsp0_valid, rsp1_valid}, 2'b10);
    chk("rd5_data", rsp_rdata, pre(5));
    tick();
    chk("rd5_rsp_once", rsp0_valid, 0);

    // lone port 1 read of addr 4 leaves the pointer favouring port 0
    req1_valid = 1; req1_addr = 4; #1;
    chk("rd4_ready1", req1_ready, 1);
    tick(); req1_valid = 0;
    tick(); tick();
    chk("rd4_rsp1", {rsp0_valid, rsp1_valid}, 2'b01);
    chk("rd4_data", rsp_rdata, pre(4));

    // both ports contend: grants 0,1,0,1 and in-order responses
    req0_addr = 1; req1_addr = 2;
    for (int c = 0; c < 7; c++) begin
      req0_valid = (c < 4); req1_valid = (c < 4); #1;
      if (c < 4) chk("rr_grant", {req0_ready, req1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01);
      if (c >= 3) begin
        chk("rr_rsp", {rsp0_valid, rsp1_valid}, ((c - 3) % 2 == 0) ? 2'b10 : 2'b01);
        chk("rr_data", rsp_rdata, ((c - 3) % 2 == 0) ? pre(1) : pre(2));
      end
      tick();
    end

    // read-after-write: port 1 writes addr 3, port 0 reads it next cycle
    req1_valid = 1; req1_we = 1; req1_addr = 3; req1_wdata = W3; #1;
    chk("raw_wr_ready", req1_ready, 1);
    tick(); req1_valid = 0; req1_we = 0;
    req0_valid = 1; req0_addr = 3; #1;
    chk("raw_rd_ready", req0_ready, 1);
    chk("raw_mem_wr", {mem_we, mem_waddr, mem_wdata}, {1'b1, 4'd3, W3});
    tick(); req0_valid = 0; #1;
    chk("raw_we_once", mem_we, 0);
    tick(); tick();
    chk("raw_rsp", rsp0_valid, 1);
    chk("raw_data", rsp_rdata, W3);

    // read in flight, then init_start (beats a port 1 request), sweep runs
    req0_valid = 1; req0_addr = 6; #1;
    chk("pre_init_ready", req0_ready, 1);
    tick(); req0_valid = 0;
    init_start = 1; req1_valid = 1; req1_addr = 0; #1;
    chk("init_wins", req1_ready, 0);
    tick(); init_start = 0;
    busy_cnt = 0; done_cnt = 0; rdy_bad = 0; rsp_bad = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      init_start = (cyc == 10); #1;
      if (req0_ready || req1_ready) rdy_bad++;
      if (init_busy) busy_cnt++;
      if (init_done) begin
        done_cnt++;
        chk("done_not_busy", init_busy, 0);
        req1_valid = 0;
      end
      if (cyc == 1) begin
        chk("drain_rsp", rsp0_valid, 1);
        chk("drain_data", rsp_rdata, pre(6));
      end else if (rsp0_valid || rsp1_valid) begin
        rsp_bad++;
      end
      tick();
    end
    init_start = 0;
    chk("busy_len", busy_cnt, 20);
    chk("done_pulses", done_cnt, 1);
    chk("ready_during_init", rdy_bad, 0);
    chk("sweep_no_rsp", rsp_bad, 0);

    // read back every record after the sweep
    for (int c = 0; c < 19; c++) begin
      req0_valid = (c < 16); req0_addr = 4'(c); #1;
      if (c < 16) chk("rb_ready", req0_ready, 1);
      if (c >= 3) begin
        chk("rb_rsp", rsp0_valid, 1);
        chk("rb_data", rsp_rdata, (c - 3 == 3) ? swept(W3) : swept(pre(c - 3)));
      end
      tick();
    end
    req0_valid = 0;

    // reset while the sweep is reading addr 7
    init_start = 1;
    tick(); init_start = 0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (init_busy && mem_raddr == 4'd7) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("sweep_reached_7", found, 1);
    #1 rstn = 0; #1;
    chk("midsweep_reset_outs", outs(), '0);
    req0_valid = 1; req0_addr = 0; #1;
    chk("ready_in_reset", req0_ready, 0);
    tick(); rstn = 1; #1;
    chk("after_rst_idle", {init_busy, req0_ready}, 2'b01);
    tick(); req0_valid = 0;
    tick(); tick();
    chk("after_rst_rsp", rsp0_valid, 1);
    chk("after_rst_data", rsp_rdata, swept(pre(0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
